rs_fu_issue_tracker: RTL and testbench

- Sits directly downstream of the RS-to-FU scheduler.
- Consumes its per-RS dispatch enables and FU assignments, and latches each issued instruction's tag and source RS into the target FU slot.
- Tracks each FU's occupancy through a fixed-latency execute, then arbitrates finished FUs onto the CDB with a valid/ready handshake.
- Drives fu_available back to the scheduler, closing the issue loop.

---
 rtl/rs_pkg.sv | 19 +
 rtl/fu_slot_fsm.sv | 83 ++++++++
 rtl/rs_fu_issue_tracker.sv | 126 ++++++++++++
 tb/tb_rs_fu_issue_tracker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared types for the RS-to-FU issue tracker: FU slot states,
// tag type and the index-width helper.
package rs_pkg;

    localparam int TAG_W = 6;

    typedef logic [TAG_W-1:0] tag_t;

    typedef enum logic [1:0] {
        FU_IDLE,
        FU_BUSY,
        FU_DONE
    } fu_state_t;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fu_slot_fsm.sv
// One functional-unit slot: IDLE/BUSY/DONE FSM, latency counter and
// latched tag / source-RS index.
module fu_slot_fsm
    import rs_pkg::*;
#(
    parameter int FU_LATENCY   = 3,
    parameter int TAG_WIDTH    = 6,
    parameter int RS_IDX_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [RS_IDX_WIDTH-1:0] rs_idx_i,
    input  logic [TAG_WIDTH-1:0]    tag_i,
    input  logic                    grant_i,
    output fu_state_t               state_o,
    output logic                    start_o,
    output logic [RS_IDX_WIDTH-1:0] rs_idx_o,
    output logic [TAG_WIDTH-1:0]    tag_o
);

    localparam int CNT_W = 4;

    fu_state_t               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [RS_IDX_WIDTH-1:0] rs_idx_q, rs_idx_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic                    start_q, start_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rs_idx_d = rs_idx_q;
        tag_d    = tag_q;
        start_d  = 1'b0;
        unique case (state_q)
            FU_IDLE: begin
                if (start_i) begin
                    state_d  = FU_BUSY;
                    cnt_d    = CNT_W'(FU_LATENCY - 1);
                    rs_idx_d = rs_idx_i;
                    tag_d    = tag_i;
                    start_d  = 1'b1;
                end
            end
            FU_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = FU_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FU_DONE: begin
                if (grant_i) begin
                    state_d = FU_IDLE;
                end
            end
            default: state_d = FU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= FU_IDLE;
            cnt_q    <= '0;
            rs_idx_q <= '0;
            tag_q    <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rs_idx_q <= rs_idx_d;
            tag_q    <= tag_d;
            start_q  <= start_d;
        end
    end

    assign state_o  = state_q;
    assign start_o  = start_q;
    assign rs_idx_o = rs_idx_q;
    assign tag_o    = tag_q;

endmodule

// File: rtl/rs_fu_issue_tracker.sv
// Latches scheduler dispatches into FU slots, tracks execute latency
// and arbitrates finished FUs onto the CDB, lowest index first.
module rs_fu_issue_tracker
    import rs_pkg::*;
#(
    parameter int NUM_OF_RS    = 4,
    parameter int NUM_OF_FU    = 2,
    parameter int FU_LATENCY   = 3,
    parameter int TAG_WIDTH    = 6,
    parameter int FU_IDX_WIDTH = idx_width(NUM_OF_FU),
    parameter int RS_IDX_WIDTH = idx_width(NUM_OF_RS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_OF_RS-1:0]    rs_dispatch_en,
    input  logic [FU_IDX_WIDTH-1:0] rs_fu_assign [NUM_OF_RS],
    input  logic [TAG_WIDTH-1:0]    rs_tag       [NUM_OF_RS],
    output logic [NUM_OF_FU-1:0]    fu_available,
    output logic [NUM_OF_FU-1:0]    fu_start,
    output logic [RS_IDX_WIDTH-1:0] fu_rs_idx    [NUM_OF_FU],
    output logic [TAG_WIDTH-1:0]    fu_tag       [NUM_OF_FU],
    output logic                    cdb_valid,
    output logic [TAG_WIDTH-1:0]    cdb_tag,
    output logic [FU_IDX_WIDTH-1:0] cdb_fu_idx,
    input  logic                    cdb_ready,
    output logic                    dispatch_err
);

    fu_state_t               fu_state [NUM_OF_FU];
    logic [NUM_OF_FU-1:0]    hit;
    logic [NUM_OF_FU-1:0]    slot_start;
    logic [NUM_OF_FU-1:0]    grant;
    logic [RS_IDX_WIDTH-1:0] sel_rs  [NUM_OF_FU];
    logic [TAG_WIDTH-1:0]    sel_tag [NUM_OF_FU];
    logic                    dispatch_err_q, dispatch_err_d;

    // Lowest RS wins each FU; every dropped or illegal request is sticky-flagged.
    always_comb begin
        dispatch_err_d = dispatch_err_q;
        hit            = '0;
        slot_start     = '0;
        for (int f = 0; f < NUM_OF_FU; f++) begin
            sel_rs[f]  = '0;
            sel_tag[f] = '0;
        end
        for (int r = 0; r < NUM_OF_RS; r++) begin
            if (rs_dispatch_en[r]) begin
                if (32'(rs_fu_assign[r]) >= NUM_OF_FU) begin
                    dispatch_err_d = 1'b1;
                end
                for (int f = 0; f < NUM_OF_FU; f++) begin
                    if (rs_fu_assign[r] == FU_IDX_WIDTH'(f)) begin
                        if (hit[f]) begin
                            dispatch_err_d = 1'b1;
                        end else begin
                            hit[f]     = 1'b1;
                            sel_rs[f]  = RS_IDX_WIDTH'(r);
                            sel_tag[f] = rs_tag[r];
                        end
                    end
                end
            end
        end
        for (int f = 0; f < NUM_OF_FU; f++) begin
            if (hit[f]) begin
                if (fu_state[f] == FU_IDLE) begin
                    slot_start[f] = 1'b1;
                end else begin
                    dispatch_err_d = 1'b1;
                end
            end
        end
    end

    // Descending scan so the lowest DONE index is the one left selected.
    always_comb begin
        cdb_valid  = 1'b0;
        cdb_tag    = '0;
        cdb_fu_idx = '0;
        for (int f = NUM_OF_FU - 1; f >= 0; f--) begin
            if (fu_state[f] == FU_DONE) begin
                cdb_valid  = 1'b1;
                cdb_tag    = fu_tag[f];
                cdb_fu_idx = FU_IDX_WIDTH'(f);
            end
        end
    end

    always_comb begin
        for (int f = 0; f < NUM_OF_FU; f++) begin
            grant[f] = cdb_valid && cdb_ready &&
                       (cdb_fu_idx == FU_IDX_WIDTH'(f));
            fu_available[f] = (fu_state[f] == FU_IDLE);
        end
    end

    for (genvar g = 0; g < NUM_OF_FU; g++) begin : g_slot
        fu_slot_fsm #(
            .FU_LATENCY   (FU_LATENCY),
            .TAG_WIDTH    (TAG_WIDTH),
            .RS_IDX_WIDTH (RS_IDX_WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .start_i  (slot_start[g]),
            .rs_idx_i (sel_rs[g]),
            .tag_i    (sel_tag[g]),
            .grant_i  (grant[g]),
            .state_o  (fu_state[g]),
            .start_o  (fu_start[g]),
            .rs_idx_o (fu_rs_idx[g]),
            .tag_o    (fu_tag[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dispatch_err_q <= 1'b0;
        end else begin
            dispatch_err_q <= dispatch_err_d;
        end
    end

    assign dispatch_err = dispatch_err_q;

endmodule

// File: tb/tb_rs_fu_issue_tracker.sv
// Randomized and directed bench for rs_fu_issue_tracker against a
// timestamp-based occupancy model.
module tb_rs_fu_issue_tracker;
    import rs_pkg::*;

    localparam int NR = 4;
    localparam int NF = 2;
    localparam int L  = 3;
    localparam int TW = 6;
    localparam int FW = 1;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] en;
    logic [FW-1:0] asg  [NR];
    logic [TW-1:0] tg   [NR];
    logic [NF-1:0] avail;
    logic [NF-1:0] start;
    logic [RW-1:0] rsidx[NF];
    logic [TW-1:0] ftag [NF];
    logic          cv;
    logic [TW-1:0] ct;
    logic [FW-1:0] cf;
    logic          crdy;
    logic          err;

    always #5 clk = ~clk;

    rs_fu_issue_tracker #(
        .NUM_OF_RS  (NR),
        .NUM_OF_FU  (NF),
        .FU_LATENCY (L),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rs_dispatch_en (en),
        .rs_fu_assign   (asg),
        .rs_tag         (tg),
        .fu_available   (avail),
        .fu_start       (start),
        .fu_rs_idx      (rsidx),
        .fu_tag         (ftag),
        .cdb_valid      (cv),
        .cdb_tag        (ct),
        .cdb_fu_idx     (cf),
        .cdb_ready      (crdy),
        .dispatch_err   (err)
    );

    // Model: an occupied FU finishes L edges after its dispatch edge.
    bit m_occ  [NF];
    int m_edge [NF];
    int m_tag  [NF];
    int m_rs   [NF];
    bit m_start[NF];
    bit m_err;
    int cyc;
    int passed;
    int total;

    function automatic bit m_done(int f);
        return m_occ[f] && (cyc >= m_edge[f] + L);
    endfunction

    function automatic int m_sel();
        int s = -1;
        for (int f = NF - 1; f >= 0; f--) if (m_done(f)) s = f;
        return s;
    endfunction

    task automatic check(string name, int got, int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)",
                      name, got, exp, cyc);
    endtask

    task automatic model_edge();
        int sel;
        bit claimed[NF];
        int who[NF];
        bit accept[NF];
        sel = m_sel();
        cyc++;
        if (!rst) begin
            for (int f = 0; f < NF; f++) begin
                m_occ[f] = 0; m_tag[f] = 0; m_rs[f] = 0; m_start[f] = 0;
            end
            m_err = 0;
            return;
        end
        for (int f = 0; f < NF; f++) begin
            claimed[f] = 0; who[f] = 0; accept[f] = 0;
        end
        for (int r = 0; r < NR; r++) begin
            if (en[r]) begin
                int a = int'(asg[r]);
                if (a >= NF) m_err = 1;
                else if (claimed[a]) m_err = 1;
                else begin claimed[a] = 1; who[a] = r; end
            end
        end
        for (int f = 0; f < NF; f++) begin
            if (claimed[f]) begin
                if (m_occ[f]) m_err = 1;
                else accept[f] = 1;
            end
        end
        if (sel >= 0 && crdy) m_occ[sel] = 0;
        for (int f = 0; f < NF; f++) begin
            m_start[f] = accept[f];
            if (accept[f]) begin
                m_occ[f]  = 1;
                m_edge[f] = cyc;
                m_rs[f]   = who[f];
                m_tag[f]  = int'(tg[who[f]]);
            end
        end
    endtask

    task automatic compare();
        int s = m_sel();
        for (int f = 0; f < NF; f++) begin
            check($sformatf("avail%0d", f), int'(avail[f]), int'(!m_occ[f]));
            check($sformatf("start%0d", f), int'(start[f]), int'(m_start[f]));
            check($sformatf("tag%0d", f), int'(ftag[f]), m_tag[f]);
            check($sformatf("rsidx%0d", f), int'(rsidx[f]), m_rs[f]);
        end
        check("cdb_valid", int'(cv), int'(s >= 0));
        if (s >= 0) begin
            check("cdb_tag", int'(ct), m_tag[s]);
            check("cdb_fu_idx", int'(cf), s);
        end
        check("dispatch_err", int'(err), int'(m_err));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic idle_inputs();
        en = '0;
        for (int r = 0; r < NR; r++) begin asg[r] = '0; tg[r] = '0; end
    endtask

    task automatic do_reset(int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) cycle();
        rst = 1'b1;
    endtask

    initial begin
        passed = 0; total = 0; cyc = 0; m_err = 0;
        for (int f = 0; f < NF; f++) begin
            m_occ[f] = 0; m_edge[f] = 0; m_tag[f] = 0;
            m_rs[f] = 0; m_start[f] = 0;
        end
        idle_inputs();
        crdy = 1'b1;
        rst  = 1'b0;
        @(negedge clk);
        do_reset(2);
        cycle();
        check("rst_avail", int'(avail), 3);
        check("rst_cv", int'(cv), 0);

        // RS2 -> FU1, tag 0x15
        en = 4'b0100; asg[2] = 1'b1; tg[2] = 6'h15;
        cycle();
        idle_inputs();
        check("single_start1", int'(start[1]), 1);
        for (int i = 0; i < L; i++) cycle();
        check("single_cv", int'(cv), 1);
        check("single_ct", int'(ct), 'h15);
        cycle();
        check("single_avail1", int'(avail[1]), 1);

        // Both FUs done together, CDB stalled
        en = 4'b0011; asg[0] = 1'b0; tg[0] = 6'h03; asg[1] = 1'b1; tg[1] = 6'h07;
        crdy = 1'b0;
        cycle();
        idle_inputs();
        for (int i = 0; i < L + 5; i++) cycle();
        check("stall_ct", int'(ct), 'h03);
        crdy = 1'b1;
        cycle();
        check("second_ct", int'(ct), 'h07);
        cycle();
        check("both_idle", int'(avail), 3);

        // RS0 and RS3 collide on FU0
        en = 4'b1001; asg[0] = 1'b0; asg[3] = 1'b0; tg[0] = 6'h11; tg[3] = 6'h22;
        cycle();
        idle_inputs();
        check("collide_rs", int'(rsidx[0]), 0);
        check("collide_err", int'(err), 1);
        for (int i = 0; i < L + 2; i++) cycle();
        check("err_sticky", int'(err), 1);

        // Dispatch to a busy FU
        do_reset(1);
        en = 4'b0010; asg[1] = 1'b0; tg[1] = 6'h2a;
        cycle();
        en = 4'b0100; asg[2] = 1'b0; tg[2] = 6'h3c;
        cycle();
        idle_inputs();
        check("busy_tag", int'(ftag[0]), 'h2a);
        check("busy_err", int'(err), 1);
        for (int i = 0; i < L + 2; i++) cycle();

        // Reset while FU1 is DONE
        do_reset(1);
        crdy = 1'b0;
        en = 4'b0001; asg[0] = 1'b1; tg[0] = 6'h19;
        cycle();
        idle_inputs();
        for (int i = 0; i < L; i++) cycle();
        check("pre_rst_cv", int'(cv), 1);
        do_reset(1);
        check("rst_done_cv", int'(cv), 0);
        check("rst_done_avail", int'(avail), 3);
        crdy = 1'b1;
        for (int i = 0; i < L + 2; i++) cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en = NR'($urandom_range(0, 15) & $urandom_range(0, 15) &
                     $urandom_range(0, 15));
            for (int r = 0; r < NR; r++) begin
                asg[r] = FW'($urandom_range(0, 1));
                tg[r]  = TW'($urandom_range(0, 63));
            end
            crdy = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 79) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
